// File: rtl/ws2811_frame_receiver_pkg.sv
// Shared definitions for the ws2811 frame receiver: default local byte count,
// FSM state encodings and frame rejection codes.
package ws2811_frame_receiver_pkg;

  localparam int OWN_BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_OWN  = 2'd2,
    ST_FWD  = 2'd3
  } rxState_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_PARTIAL = 2'd2;
  localparam logic [1:0] ERR_BOTH    = 2'd3;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ws2811_frame_receiver_assembler.sv
// Bit assembler: edge detection on the decoder's bit clock and active flag,
// MSB-first shift register, bit counter and a one-cycle byte strobe.
module ws2811_bit_assembler (
  input  logic       masterClk,
  input  logic       reset,
  input  logic       bitData,
  input  logic       bitClk,
  input  logic       lineActive,
  input  logic       clearBits,
  output logic       activeRise,
  output logic       activeFall,
  output logic       byteStrobe,
  output logic [7:0] byteData,
  output logic [2:0] bitCnt
);

  logic       prevBitClk;
  logic       prevActive;
  logic       sample;
  logic [7:0] shiftReg;

  assign sample     = bitClk & ~prevBitClk & lineActive;
  assign activeRise = lineActive & ~prevActive;
  assign activeFall = ~lineActive & prevActive;
  assign byteData   = shiftReg;

  // Edge-detect registers always track their inputs so that leaving reset with
  // the line already active does not fabricate a rising edge.
  always_ff @(posedge masterClk) begin
    prevBitClk <= bitClk;
    prevActive <= lineActive;
    if (reset) begin
      shiftReg   <= 8'd0;
      bitCnt     <= 3'd0;
      byteStrobe <= 1'b0;
    end else begin
      byteStrobe <= 1'b0;
      if (sample) begin
        shiftReg   <= {shiftReg[6:0], bitData};
        bitCnt     <= clearBits ? 3'd1 : bitCnt + 3'd1;
        byteStrobe <= !clearBits && (bitCnt == 3'd7);
      end else if (clearBits) begin
        bitCnt <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/ws2811_frame_receiver.sv
// ws2811 frame receiver: keeps the first OWN_BYTES bytes of each frame for local
// use, forwards the rest downstream, and accepts a frame only if it ends cleanly.
module ws2811_frame_receiver
  import ws2811_frame_receiver_pkg::*;
#(
  parameter int OWN_BYTES = OWN_BYTES_DEFAULT
) (
  input  logic                   masterClk,
  input  logic                   reset,
  input  logic                   bitData,
  input  logic                   bitClk,
  input  logic                   lineActive,
  output logic [8*OWN_BYTES-1:0] ownData,
  output logic                   frameValid,
  output logic                   frameErr,
  output logic [1:0]             errCode,
  output logic [7:0]             fwdByte,
  output logic                   fwdValid,
  output logic [7:0]             byteCnt
);

  localparam logic [7:0] OWN_CNT  = 8'(OWN_BYTES);
  localparam logic [7:0] LAST_OWN = 8'(OWN_BYTES - 1);

  rxState_t               state;
  logic                   evalPending;
  logic [8*OWN_BYTES-1:0] staging;

  logic       activeRise;
  logic       activeFall;
  logic       byteStrobe;
  logic [7:0] byteData;
  logic [2:0] bitCnt;
  logic       clearBits;
  logic       shortFrame;
  logic       partialByte;

  assign clearBits   = (state == ST_IDLE) && activeRise;
  assign shortFrame  = byteCnt < OWN_CNT;
  assign partialByte = bitCnt != 3'd0;

  ws2811_bit_assembler uAssembler (
    .masterClk  (masterClk),
    .reset      (reset),
    .bitData    (bitData),
    .bitClk     (bitClk),
    .lineActive (lineActive),
    .clearBits  (clearBits),
    .activeRise (activeRise),
    .activeFall (activeFall),
    .byteStrobe (byteStrobe),
    .byteData   (byteData),
    .bitCnt     (bitCnt)
  );

  always_ff @(posedge masterClk) begin
    if (reset) begin
      // A frame cut by reset must not be picked up half-way: wait it out in SKIP.
      state       <= lineActive ? ST_SKIP : ST_IDLE;
      evalPending <= 1'b0;
      staging     <= '0;
      ownData     <= '0;
      frameValid  <= 1'b0;
      frameErr    <= 1'b0;
      errCode     <= ERR_NONE;
      fwdByte     <= 8'd0;
      fwdValid    <= 1'b0;
      byteCnt     <= 8'd0;
    end else begin
      frameValid <= 1'b0;
      frameErr   <= 1'b0;
      fwdValid   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (activeRise) begin
            byteCnt <= 8'd0;
            state   <= (OWN_BYTES == 0) ? ST_FWD : ST_OWN;
          end
        end
        ST_SKIP: begin
          if (activeFall) state <= ST_IDLE;
        end
        default: begin
          // Evaluation waits one cycle after the fall so a byte strobe that
          // lands on the fall cycle is still counted.
          if (evalPending) begin
            evalPending <= 1'b0;
            state       <= ST_IDLE;
            if (!shortFrame && !partialByte) begin
              ownData    <= staging;
              frameValid <= 1'b1;
            end else begin
              frameErr <= 1'b1;
              errCode  <= {partialByte, shortFrame};
            end
          end else begin
            if (activeFall) evalPending <= 1'b1;
            if (byteStrobe) begin
              byteCnt <= satInc(byteCnt);
              if (state == ST_OWN) begin
                for (int k = 0; k < OWN_BYTES; k++) begin
                  if (byteCnt == 8'(k)) staging[8*(OWN_BYTES-1-k) +: 8] <= byteData;
                end
                if (byteCnt == LAST_OWN) state <= ST_FWD;
              end else begin
                fwdByte  <= byteData;
                fwdValid <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_frame_receiver.sv
// Bench for ws2811_frame_receiver: directed and random frames checked against a
// frame-level reference model of accepted bytes, forwarded bytes and error codes.
module tb_ws2811_frame_receiver;

  logic        masterClk = 1'b0;
  logic        reset;
  logic        bitData;
  logic        bitClk;
  logic        lineActive;
  logic [31:0] ownData;
  logic        frameValid;
  logic        frameErr;
  logic [1:0]  errCode;
  logic [7:0]  fwdByte;
  logic        fwdValid;
  logic [7:0]  byteCnt;

  ws2811_frame_receiver #(.OWN_BYTES(4)) dut (
    .masterClk  (masterClk),
    .reset      (reset),
    .bitData    (bitData),
    .bitClk     (bitClk),
    .lineActive (lineActive),
    .ownData    (ownData),
    .frameValid (frameValid),
    .frameErr   (frameErr),
    .errCode    (errCode),
    .fwdByte    (fwdByte),
    .fwdValid   (fwdValid),
    .byteCnt    (byteCnt)
  );

  always #5 masterClk = ~masterClk;

  int nChecks = 0;
  int nPass   = 0;

  int         fvCnt = 0;
  int         feCnt = 0;
  int         fwdCnt = 0;
  int         bothCnt = 0;
  logic [7:0] fwdQ[$];

  logic [31:0] modelOwn = 32'd0;
  logic [1:0]  modelErr = 2'd0;

  always @(negedge masterClk) begin
    if (frameValid) fvCnt <= fvCnt + 1;
    if (frameErr) feCnt <= feCnt + 1;
    if (frameValid && frameErr) bothCnt <= bothCnt + 1;
    if (fwdValid) begin
      fwdCnt <= fwdCnt + 1;
      fwdQ.push_back(fwdByte);
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic clearMonitor();
    @(negedge masterClk);
    fvCnt   = 0;
    feCnt   = 0;
    fwdCnt  = 0;
    bothCnt = 0;
    fwdQ.delete();
  endtask

  task automatic sendBit(input logic b);
    @(negedge masterClk);
    bitData = b;
    bitClk  = 1'b1;
    @(negedge masterClk);
    bitClk  = 1'b0;
    @(negedge masterClk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
  endtask

  // Sends one complete frame, then checks the outcome against the frame rules.
  task automatic runFrame(input logic [7:0] bytes[$], input int extraBits, input string name);
    int  n;
    int  expFwd;
    bit  good;
    clearMonitor();
    lineActive = 1'b1;
    repeat (3) @(negedge masterClk);
    foreach (bytes[i]) sendByte(bytes[i]);
    for (int i = 0; i < extraBits; i++) sendBit(1'($urandom_range(0, 1)));
    @(negedge masterClk);
    lineActive = 1'b0;
    repeat (8) @(negedge masterClk);

    n      = bytes.size();
    good   = (n >= 4) && (extraBits == 0);
    expFwd = (n > 4) ? n - 4 : 0;
    if (good) modelOwn = {bytes[0], bytes[1], bytes[2], bytes[3]};
    else modelErr = {extraBits != 0, n < 4};

    checkVal({name, " frameValid"}, 64'(fvCnt), good ? 64'd1 : 64'd0);
    checkVal({name, " frameErr"}, 64'(feCnt), good ? 64'd0 : 64'd1);
    checkVal({name, " exclusive"}, 64'(bothCnt), 64'd0);
    checkVal({name, " errCode"}, 64'(errCode), 64'(modelErr));
    checkVal({name, " ownData"}, 64'(ownData), 64'(modelOwn));
    checkVal({name, " byteCnt"}, 64'(byteCnt), 64'((n > 255) ? 255 : n));
    checkVal({name, " fwdCount"}, 64'(fwdCnt), 64'(expFwd));
    for (int i = 0; i < expFwd && i < fwdQ.size(); i++)
      checkVal($sformatf("%s fwdByte[%0d]", name, i), 64'(fwdQ[i]), 64'(bytes[i+4]));
  endtask

  initial begin
    logic [7:0] fr[$];
    int         extra;

    reset      = 1'b1;
    bitData    = 1'b0;
    bitClk     = 1'b0;
    lineActive = 1'b0;
    repeat (3) @(negedge masterClk);
    checkVal("reset ownData", 64'(ownData), 64'd0);
    checkVal("reset byteCnt", 64'(byteCnt), 64'd0);
    checkVal("reset errCode", 64'(errCode), 64'd0);
    checkVal("reset pulses", 64'({frameValid, frameErr, fwdValid}), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge masterClk);

    fr = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
    runFrame(fr, 0, "frame4");
    fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'h55};
    runFrame(fr, 0, "frame6");
    fr = '{8'h11, 8'h22, 8'h33};
    runFrame(fr, 0, "short3");
    fr = '{8'h9E, 8'h8D, 8'h7C, 8'h6B};
    runFrame(fr, 3, "partial");
    fr = '{8'h12};
    runFrame(fr, 5, "shortPartial");

    for (int t = 0; t < 12; t++) begin
      fr.delete();
      for (int i = 0, n = $urandom_range(0, 9); i < n; i++) fr.push_back(8'($urandom));
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      runFrame(fr, extra, $sformatf("rand%0d", t));
    end

    // Reset in the middle of a frame with the line still active.
    clearMonitor();
    lineActive = 1'b1;
    repeat (3) @(negedge masterClk);
    sendByte(8'hDE);
    sendByte(8'hAD);
    reset = 1'b1;
    repeat (2) @(negedge masterClk);
    checkVal("midReset ownData", 64'(ownData), 64'd0);
    checkVal("midReset byteCnt", 64'(byteCnt), 64'd0);
    reset = 1'b0;
    sendByte(8'hBE);
    sendByte(8'hEF);
    sendByte(8'h77);
    sendByte(8'h66);
    sendByte(8'h55);
    @(negedge masterClk);
    lineActive = 1'b0;
    repeat (8) @(negedge masterClk);
    modelOwn = 32'd0;
    modelErr = 2'd0;
    checkVal("skip frameValid", 64'(fvCnt), 64'd0);
    checkVal("skip frameErr", 64'(feCnt), 64'd0);
    checkVal("skip fwdCount", 64'(fwdCnt), 64'd0);
    checkVal("skip ownData", 64'(ownData), 64'd0);
    checkVal("skip byteCnt", 64'(byteCnt), 64'd0);
    checkVal("skip errCode", 64'(errCode), 64'd0);

    fr = '{8'hC0, 8'hFF, 8'hEE, 8'h01, 8'h5A};
    runFrame(fr, 0, "afterReset");

    fr.delete();
    for (int i = 0; i < 300; i++) fr.push_back(8'($urandom));
    runFrame(fr, 0, "long300");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
